// File: rtl/mod_reduce_serial.sv
// Serial constant-modulus reducer: z = x mod MOD, consuming CW operand bits per clock,
// most-significant chunk first (Horner order), with a valid/ready handshake on each side.
module mod_reduce_serial #(
   parameter int IN_W = 400,
   parameter int MOD  = 241,
   parameter int CW   = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            x,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(MOD)-1:0]     z,
   output logic                       busy
);

   localparam int MW   = $clog2(MOD);
   localparam int NCH  = (IN_W + CW - 1) / CW;
   localparam int XW   = NCH * CW;
   localparam int TW   = MW + CW;
   localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

   if ((MOD < 2) || (MOD > 65535)) begin : g_bad_mod
      $error("mod_reduce_serial: MOD must lie in 2..65535");
   end
   if ((CW < 1) || (CW > 8)) begin : g_bad_cw
      $error("mod_reduce_serial: CW must lie in 1..8");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Since acc < MOD, acc*2^CW + c < MOD*2^CW, so CW conditional subtractions of
   // the modulus scaled by 2^k (k = CW-1 .. 0) always land the value below MOD.
   function automatic logic [MW-1:0] horner_step(input logic [MW-1:0] a, input logic [CW-1:0] c);
      logic [TW-1:0] t;
      t = {a, c};
      for (int k = CW - 1; k >= 0; k--) begin
         if (t >= (TW'(MOD) << k)) begin
            t = t - (TW'(MOD) << k);
         end else begin
            t = t;
         end
      end
      return t[MW-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [MW-1:0]    acc_q, acc_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [MW-1:0]    z_q, z_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = XW'(x);
               acc_d   = {MW{1'b0}};
               cnt_d   = {CNTW{1'b0}};
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = horner_step(acc_q, x_q[XW-1 -: CW]);
            x_d   = x_q << CW;
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(NCH - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
      if (state_d == S_DONE) begin
         z_d = acc_d;
      end else begin
         z_d = {MW{1'b0}};
      end
   end

   // State, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= {XW{1'b0}};
         acc_q       <= {MW{1'b0}};
         cnt_q       <= {CNTW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         z_q         <= {MW{1'b0}};
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         z_q         <= z_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign z         = z_q;

endmodule

// File: tb/tb_mod_reduce_serial.sv
// Directed and seeded back-to-back checks of mod_reduce_serial at the default
// parameters and at IN_W=37, MOD=13, CW=4.
module tb_mod_reduce_serial;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [399:0]  x;
   logic [7:0]    z;
   logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
   logic [36:0]   s_x;
   logic [3:0]    s_z;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   mod_reduce_serial u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .z(z), .busy(busy)
   );

   mod_reduce_serial #(.IN_W(37), .MOD(13), .CW(4)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .x(s_x),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .z(s_z), .busy(s_busy)
   );

   // Bit-serial reference, deliberately unlike the chunked datapath
   function automatic int ref_mod(input logic [399:0] v, input int nbits, input int m);
      int r;
      r = 0;
      for (int i = nbits - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % m;
      return r;
   endfunction

   function automatic logic [399:0] rand_vec(input int nbits);
      logic [399:0] v;
      v = '0;
      for (int i = 0; i < nbits; i++) v[i] = 1'($urandom_range(1, 0));
      return v;
   endfunction

   // Entered #1 after an edge with the big DUT idle; scrambles x/in_valid/out_ready while busy
   task automatic run_big(input logic [399:0] xv, input int hold,
                          output logic [7:0] zv, output int lat, output bit ok);
      ok = 1'b1;
      in_valid = 1'b1; x = xv;
      @(posedge clk); #1;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
         x = ~x; in_valid = lat[0]; out_ready = lat[1];
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      zv = z;
      repeat (hold) begin
         @(posedge clk); #1;
         if (z !== zv || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || z !== 8'd0) ok = 1'b0;
   endtask

   task automatic run_small(input logic [36:0] xv, input int hold,
                            output logic [3:0] zv, output int lat, output bit ok);
      ok = 1'b1;
      s_in_valid = 1'b1; s_x = xv;
      @(posedge clk); #1;
      lat = 0;
      while (s_out_valid !== 1'b1 && lat < 200) begin
         if (s_in_ready !== 1'b0 || s_busy !== 1'b1) ok = 1'b0;
         s_x = ~s_x; s_in_valid = lat[0]; s_out_ready = lat[1];
         @(posedge clk); #1;
         lat++;
      end
      s_out_ready = 1'b0;
      zv = s_z;
      repeat (hold) begin
         @(posedge clk); #1;
         if (s_z !== zv || s_out_valid !== 1'b1 || s_in_ready !== 1'b0) ok = 1'b0;
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0; s_in_valid = 1'b0;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_busy !== 1'b0) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1; x = 400'd241; out_ready = 1'b1;
      s_in_valid = 1'b1; s_x = 37'd13; s_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (z !== 8'd0) $display("FAIL rst_z: got %0d want 0", z); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (s_in_ready !== 1'b1) $display("FAIL rst_s_in_ready: got %b want 1", s_in_ready); else pass_cnt++;
      chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL rst_s_out_valid: got %b want 0", s_out_valid); else pass_cnt++;
      chk_cnt++; if (s_busy !== 1'b0) $display("FAIL rst_s_busy: got %b want 0", s_busy); else pass_cnt++;
      rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [399:0] vx [6];
      int           vz [6];
      logic [7:0]   zv;
      int           lat;
      bit           ok;
      vx[0] = '0;             vz[0] = 0;
      vx[1] = 400'd240;       vz[1] = 240;
      vx[2] = 400'd241;       vz[2] = 0;
      vx[3] = 400'd64;        vz[3] = 64;
      vx[4] = '1;             vz[4] = 224;
      vx[5] = '0; vx[5][399] = 1'b1; vz[5] = 233;
      for (int i = 0; i < 6; i++) begin
         run_big(vx[i], 0, zv, lat, ok);
         chk_cnt++; if (zv !== 8'(vz[i])) $display("FAIL dir_z[%0d]: got %0d want %0d", i, zv, vz[i]); else pass_cnt++;
         chk_cnt++; if (lat !== 67) $display("FAIL dir_latency[%0d]: got %0d want 67", i, lat); else pass_cnt++;
         chk_cnt++; if (ok !== 1'b1) $display("FAIL dir_protocol[%0d]: got %b want 1", i, ok); else pass_cnt++;
      end
   endtask

   task automatic test_small_directed();
      logic [36:0] vx [4];
      int          vz [4];
      logic [3:0]  zv;
      int          lat;
      bit          ok;
      vx[0] = 37'd0;  vz[0] = 0;
      vx[1] = 37'd13; vz[1] = 0;
      vx[2] = 37'd100; vz[2] = 9;
      vx[3] = '1;     vz[3] = 1;
      for (int i = 0; i < 4; i++) begin
         run_small(vx[i], 1, zv, lat, ok);
         chk_cnt++; if (zv !== 4'(vz[i])) $display("FAIL small_z[%0d]: got %0d want %0d", i, zv, vz[i]); else pass_cnt++;
         chk_cnt++; if (lat !== 10) $display("FAIL small_latency[%0d]: got %0d want 10", i, lat); else pass_cnt++;
         chk_cnt++; if (ok !== 1'b1) $display("FAIL small_protocol[%0d]: got %b want 1", i, ok); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit stable;
      in_valid = 1'b1; x = 400'd1000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk_cnt++; if (lat !== 67) $display("FAIL bp_latency: got %0d want 67", lat); else pass_cnt++;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (z !== 8'd36 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      chk_cnt++; if (z !== 8'd36) $display("FAIL bp_z: got %0d want 36", z); else pass_cnt++;
      chk_cnt++; if (stable !== 1'b1) $display("FAIL bp_hold: got %b want 1", stable); else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (z !== 8'd0) $display("FAIL bp_release_z: got %0d want 0", z); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      logic [7:0] zv;
      int         lat;
      bit         ok, leaked;
      in_valid = 1'b1; x = '1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) begin @(posedge clk); #1; end
      rst = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b0;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
      leaked = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
      end
      chk_cnt++; if (leaked !== 1'b0) $display("FAIL abort_no_result: got %b want 0", leaked); else pass_cnt++;
      run_big(400'd241, 2, zv, lat, ok);
      chk_cnt++; if (zv !== 8'd0) $display("FAIL abort_next_z: got %0d want 0", zv); else pass_cnt++;
      chk_cnt++; if (lat !== 67) $display("FAIL abort_next_latency: got %0d want 67", lat); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [399:0] v;
      logic [36:0]  sv;
      logic [7:0]   zv;
      logic [3:0]   szv;
      int           lat, exp_z;
      bit           ok;
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
         v = rand_vec((n == 0) ? 12 : 400);
         exp_z = ref_mod(v, 400, 241);
         run_big(v, $urandom_range(3, 0), zv, lat, ok);
         chk_cnt++; if (zv !== 8'(exp_z) || lat !== 67 || ok !== 1'b1)
            $display("FAIL b2b_big[%0d]: got z=%0d lat=%0d ok=%b want z=%0d lat=67 ok=1", n, zv, lat, ok, exp_z);
         else pass_cnt++;
      end
      for (int n = 0; n < 16; n++) begin
         repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
         v = rand_vec(37);
         sv = v[36:0];
         exp_z = ref_mod(v, 37, 13);
         run_small(sv, $urandom_range(3, 0), szv, lat, ok);
         chk_cnt++; if (szv !== 4'(exp_z) || lat !== 10 || ok !== 1'b1)
            $display("FAIL b2b_small[%0d]: got z=%0d lat=%0d ok=%b want z=%0d lat=10 ok=1", n, szv, lat, ok, exp_z);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_small_directed();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mod_reduce_serial.md
MOD_REDUCE_SERIAL -- requirements
Module: mod_reduce_serial

Interface
REQ-001 SHALL have parameter IN_W, default 400: operand width in bits.
REQ-002 SHALL have parameter MOD, default 241: constant modulus, legal range 2..65535.
REQ-003 SHALL have parameter CW, default 6: chunk width processed per clock, legal range 1..8.
REQ-004 SHALL derive local MW = clog2(MOD), result width; MOD=241 gives MW=8.
REQ-005 SHALL derive local NCH = ceil(IN_W/CW), chunk count; defaults give NCH=67.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 in_valid  input  1  operand x is presented.
REQ-009 in_ready  output  1  block can accept an operand.
REQ-010 x  input  IN_W  operand, unsigned.
REQ-011 out_valid  output  1  z holds a finished result.
REQ-012 out_ready  input  1  consumer accepts z.
REQ-013 z  output  MW  result, x mod MOD, always less than MOD.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement three states: IDLE, RUN, DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-017 On an edge in IDLE with in_valid=1, SHALL perform the following: capture x, zero-extended on the MSB side to NCH*CW bits; clear acc to 0; clear the chunk counter to 0; enter RUN.
REQ-018 In IDLE with in_valid=0, state and all registers SHALL hold.
REQ-019 On each RUN edge, SHALL consume the most-significant unconsumed CW-bit chunk c and update acc <= (acc*2^CW + c) mod MOD (Horner order, MSB chunk first).
REQ-020 acc SHALL be held in MW bits and SHALL satisfy acc < MOD after every update.
REQ-021 The intermediate acc*2^CW + c SHALL be computed in at least MW+CW bits with no truncation.
REQ-022 On the RUN edge that consumes chunk NCH-1, SHALL enter DONE.
REQ-023 out_valid SHALL first be high exactly NCH clock edges after the accepting edge; latency SHALL be independent of operand value.
REQ-024 In DONE, out_valid SHALL be 1 and z SHALL equal acc.
REQ-025 While in DONE, z SHALL remain stable until out_ready=1.
REQ-026 On a DONE edge with out_ready=1, SHALL return to IDLE and drop out_valid.
REQ-027 in_ready SHALL rise in the cycle after the handshake edge; there is no same-cycle output-to-input overlap.
REQ-028 Outside DONE, out_valid SHALL be 0; z SHALL be held at 0 when not in DONE.
REQ-029 in_valid and x SHALL be ignored outside IDLE; a changing x during RUN SHALL NOT affect the result.
REQ-030 out_ready SHALL be ignored outside DONE.
REQ-031 A combinational path from in_valid or out_ready to any output SHALL NOT exist.
REQ-032 Elaboration SHALL fail on an illegal MOD or CW value.

Reset
REQ-033 When rst=1 at an edge, SHALL enter IDLE and clear acc, the counter and the operand register.
REQ-034 Reset values SHALL be: in_ready=1, out_valid=0, z=0, busy=0.
REQ-035 rst SHALL override any simultaneous handshake.
REQ-036 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered; the next accepted operand SHALL compute correctly.

Verification
REQ-037 Defaults, x=0 -> z=0, out_valid high exactly 67 edges after the accept edge.
REQ-038 Defaults, the following operands SHALL give the stated results: x=240 -> z=240; x=241 -> z=0; x=64 -> z=64.
REQ-039 Defaults, x=2^400-1 -> z=224; x=2^399 -> z=233.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles in DONE -> z stable, out_valid=1, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-041 Assert rst at RUN chunk 30 -> next cycle in_ready=1, out_valid=0, busy=0; a fresh x=241 SHALL then give z=0.
REQ-042 Randomised back-to-back operands with random valid/ready gaps, at defaults and at IN_W=37, MOD=13, CW=4 -> every z matches a reference model x mod MOD.
